// File: rtl/enemy_hit_gen4_pkg.sv
// Shared types and constants for the enemy hit / shield generator.
// Shield FSMs are only built when ENEMY_SHIELD_EN is defined.
package enemy_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned FCNT_W   = 7;
    localparam int unsigned N_ENEMY  = 4;

    localparam int unsigned DEF_HIT_HALF_W   = 16;
    localparam int unsigned DEF_HIT_HALF_H   = 16;
    localparam int unsigned DEF_THREAT_HALF  = 48;
    localparam int unsigned DEF_RAISE_FRAMES = 15;
    localparam int unsigned DEF_UP_FRAMES    = 60;
    localparam int unsigned DEF_COOL_FRAMES  = 90;

    typedef enum logic [1:0] {
        SH_DOWN  = 2'd0,
        SH_RAISE = 2'd1,
        SH_UP    = 2'd2,
        SH_COOL  = 2'd3
    } shield_state_t;

    // |a - b| on unsigned coordinates; one extra bit keeps the difference from wrapping.
    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        logic signed [COORD_W:0] d;
        logic signed [COORD_W:0] nd;
        d  = $signed({1'b0, a}) - $signed({1'b0, b});
        nd = -d;
        return d[COORD_W] ? nd[COORD_W-1:0] : d[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/enemy_hit_gen4_if.sv
// Bus between the hit generator and the enemy health tracker / game logic.
// master = hit generator, slave = the side supplying positions and dead flags.
interface enemy_hit_gen4_if;
    import enemy_pkg::*;

    logic                   attack_active;
    logic [COORD_W-1:0]     attack_x;
    logic [COORD_W-1:0]     attack_y;
    logic [COORD_W-1:0]     enemy_x [0:3];
    logic [COORD_W-1:0]     enemy_y [0:3];
    logic [0:3]             dead;
    logic [0:3]             enemy_hit_en;
    logic [0:3]             is_enemy_shield;

    modport master (
        input  attack_active, attack_x, attack_y, enemy_x, enemy_y, dead,
        output enemy_hit_en, is_enemy_shield
    );

    modport slave (
        output attack_active, attack_x, attack_y, enemy_x, enemy_y, dead,
        input  enemy_hit_en, is_enemy_shield
    );

endinterface

// File: rtl/enemy_hit_gen4_shield_fsm.sv
// Per-enemy frame-counted shield: DOWN -> RAISE -> UP -> COOL -> DOWN.
// Advances only on frame-edge cycles; dead forces DOWN with priority.
module enemy_shield_fsm
    import enemy_pkg::*;
#(
    parameter int unsigned RAISE_FRAMES = DEF_RAISE_FRAMES,
    parameter int unsigned UP_FRAMES    = DEF_UP_FRAMES,
    parameter int unsigned COOL_FRAMES  = DEF_COOL_FRAMES
) (
    input  logic Clk,
    input  logic Reset,
    input  logic fe,
    input  logic threat,
    input  logic dead,
    output logic shield
);

    localparam logic [FCNT_W-1:0] RAISE_LD = FCNT_W'(RAISE_FRAMES - 1);
    localparam logic [FCNT_W-1:0] UP_LD    = FCNT_W'(UP_FRAMES - 1);
    localparam logic [FCNT_W-1:0] COOL_LD  = FCNT_W'(COOL_FRAMES - 1);

    shield_state_t      state_q, state_d;
    logic [FCNT_W-1:0]  cnt_q, cnt_d;
    logic               shield_q, shield_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (fe) begin
            if (dead) begin
                state_d = SH_DOWN;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    SH_DOWN: begin
                        if (threat) begin
                            state_d = SH_RAISE;
                            cnt_d   = RAISE_LD;
                        end
                    end
                    SH_RAISE: begin
                        if (cnt_q == '0) begin
                            state_d = SH_UP;
                            cnt_d   = UP_LD;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    SH_UP: begin
                        if (cnt_q == '0) begin
                            state_d = SH_COOL;
                            cnt_d   = COOL_LD;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    SH_COOL: begin
                        if (cnt_q == '0) begin
                            state_d = SH_DOWN;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_d = SH_DOWN;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
        // Dead already forced DOWN above, so UP here implies alive.
        shield_d = fe ? (state_d == SH_UP) : shield_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= SH_DOWN;
            cnt_q    <= '0;
            shield_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shield_q <= shield_d;
        end
    end

    assign shield = shield_q;

endmodule

// File: rtl/enemy_hit_gen4.sv
// Generates per-frame hit levels and shield flags for four enemies.
// Shield FSMs are built only when ENEMY_SHIELD_EN is defined; otherwise shields read 0.
module enemy_hit_gen4
    import enemy_pkg::*;
#(
    parameter int unsigned HIT_HALF_W   = DEF_HIT_HALF_W,
    parameter int unsigned HIT_HALF_H   = DEF_HIT_HALF_H,
    parameter int unsigned THREAT_HALF  = DEF_THREAT_HALF,
    parameter int unsigned RAISE_FRAMES = DEF_RAISE_FRAMES,
    parameter int unsigned UP_FRAMES    = DEF_UP_FRAMES,
    parameter int unsigned COOL_FRAMES  = DEF_COOL_FRAMES
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    enemy_hit_gen4_if.master bus
);

    localparam logic [COORD_W-1:0] HIT_W_LIM  = COORD_W'(HIT_HALF_W);
    localparam logic [COORD_W-1:0] HIT_H_LIM  = COORD_W'(HIT_HALF_H);
    localparam logic [COORD_W-1:0] THREAT_LIM = COORD_W'(THREAT_HALF);

    logic frame_clk_q;
    logic fe_q;

    // frame_clk is treated as a slow level; a rising edge yields one fe_q pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_q <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk;
            fe_q        <= frame_clk & ~frame_clk_q;
        end
    end

    for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_enemy
        logic [COORD_W-1:0] adx;
        logic [COORD_W-1:0] ady;
        logic               hit_d;
        logic               hit_q;
        logic               threat;

        assign adx    = abs_diff(bus.attack_x, bus.enemy_x[gi]);
        assign ady    = abs_diff(bus.attack_y, bus.enemy_y[gi]);
        assign hit_d  = bus.attack_active & ~bus.dead[gi] & (adx < HIT_W_LIM) & (ady < HIT_H_LIM);
        assign threat = bus.attack_active & (adx < THREAT_LIM) & (ady < THREAT_LIM);

        // Held for the whole frame so the tracker samples a stable level.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                hit_q <= 1'b0;
            end else if (fe_q) begin
                hit_q <= hit_d;
            end
        end

        assign bus.enemy_hit_en[gi] = hit_q;

`ifdef ENEMY_SHIELD_EN
        enemy_shield_fsm #(
            .RAISE_FRAMES (RAISE_FRAMES),
            .UP_FRAMES    (UP_FRAMES),
            .COOL_FRAMES  (COOL_FRAMES)
        ) u_shield (
            .Clk    (Clk),
            .Reset  (Reset),
            .fe     (fe_q),
            .threat (threat),
            .dead   (bus.dead[gi]),
            .shield (bus.is_enemy_shield[gi])
        );
`else
        logic threat_unused;
        assign threat_unused            = threat;
        assign bus.is_enemy_shield[gi]  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_enemy_hit_gen4.sv
// Directed + randomized frames for enemy_hit_gen4, checked against a
// timeline model (shield up while frames-since-trigger lies in the UP window).
module tb_enemy_hit_gen4;

    localparam int R  = 15;
    localparam int U  = 60;
    localparam int C  = 90;
    localparam int HW = 16;
    localparam int HH = 16;
    localparam int TH = 48;
`ifdef ENEMY_SHIELD_EN
    localparam bit SH_ON = 1'b1;
`else
    localparam bit SH_ON = 1'b0;
`endif

    logic Clk       = 1'b0;
    logic Reset     = 1'b1;
    logic frame_clk = 1'b0;

    always #5 Clk = ~Clk;

    enemy_hit_gen4_if bus();

    enemy_hit_gen4 dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int fidx  = 0;
    int trig [4];
    logic [0:3] exp_hit, exp_sh, prev_hit, prev_sh;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s (frame %0d): got %0h expected %0h", tag, fidx, got, exp);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Reference: a shield is triggered at frame f; it is up for frames f+R .. f+R+U-1
    // and the enemy can only be re-triggered once more than R+U+C frames have passed.
    task automatic model_frame();
        prev_hit = exp_hit;
        prev_sh  = exp_sh;
        for (int i = 0; i < 4; i++) begin
            int dx, dy;
            bit thr, dd;
            dx  = absd(int'(bus.attack_x), int'(bus.enemy_x[i]));
            dy  = absd(int'(bus.attack_y), int'(bus.enemy_y[i]));
            dd  = bus.dead[i];
            exp_hit[i] = bus.attack_active && !dd && (dx < HW) && (dy < HH);
            thr = bus.attack_active && (dx < TH) && (dy < TH);
            if (dd)
                trig[i] = -1;
            else if (thr && (trig[i] < 0 || fidx - trig[i] > R + U + C))
                trig[i] = fidx;
            exp_sh[i] = SH_ON && trig[i] >= 0 && (fidx - trig[i] >= R) && (fidx - trig[i] < R + U);
        end
        fidx++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) trig[i] = -1;
        exp_hit = '0;
        exp_sh  = '0;
    endtask

    task automatic randomize_inputs();
        bus.attack_active = 1'($urandom_range(0, 1));
        bus.attack_x      = 10'($urandom_range(100, 300));
        bus.attack_y      = 10'($urandom_range(100, 300));
        for (int i = 0; i < 4; i++) begin
            bus.enemy_x[i] = 10'($urandom_range(100, 300));
            bus.enemy_y[i] = 10'($urandom_range(100, 300));
            bus.dead[i]    = ($urandom_range(0, 19) == 0);
        end
    endtask

    task automatic set_pos(input int i, input int x, input int y);
        bus.enemy_x[i] = 10'(x);
        bus.enemy_y[i] = 10'(y);
    endtask

    // Called #1 after a rising clock edge; leaves the bench #1 after a rising edge.
    task automatic frame(input int hold, input bit scramble);
        model_frame();
        frame_clk = 1'b1;
        @(posedge Clk); #1;
        chk("hit_pre",    32'(bus.enemy_hit_en),    32'(prev_hit));
        chk("shield_pre", 32'(bus.is_enemy_shield), 32'(prev_sh));
        @(posedge Clk); #1;
        chk("hit",        32'(bus.enemy_hit_en),    32'(exp_hit));
        chk("shield",     32'(bus.is_enemy_shield), 32'(exp_sh));
        $display("frame %0d hit=%b shield=%b", fidx - 1, bus.enemy_hit_en, bus.is_enemy_shield);
        if (scramble) randomize_inputs();
        repeat (hold) @(posedge Clk);
        #1;
        frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("hit_hold",    32'(bus.enemy_hit_en),    32'(exp_hit));
        chk("shield_hold", 32'(bus.is_enemy_shield), 32'(exp_sh));
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_hit", 32'(bus.enemy_hit_en),    32'd0);
        chk("rst_sh",  32'(bus.is_enemy_shield), 32'd0);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic clear_inputs();
        bus.attack_active = 1'b0;
        bus.attack_x      = '0;
        bus.attack_y      = '0;
        bus.dead          = '0;
        for (int i = 0; i < 4; i++) set_pos(i, 900, 900);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int up_cnt, rise;
        clear_inputs();
        model_reset();
        exp_hit = '0;
        exp_sh  = '0;

        // Reset, then idle frames with enemies close but no attack.
        @(posedge Clk); #1;
        do_reset();
        bus.attack_x = 10'd200; bus.attack_y = 10'd200;
        for (int i = 0; i < 4; i++) set_pos(i, 200 + i, 200);
        for (int k = 0; k < 10; k++) frame(1, 1'b0);

        // Hit box boundaries.
        do_reset();
        bus.attack_active = 1'b1;
        bus.attack_x = 10'd100; bus.attack_y = 10'd100;
        set_pos(0, 85, 100);
        set_pos(1, 115, 100);
        set_pos(2, 700, 700);
        set_pos(3, 100, 84);
        frame(3, 1'b0);
        chk("e1_hit_dx15",  32'(bus.enemy_hit_en[1]), 32'd1);
        chk("e0_hit_dxm15", 32'(bus.enemy_hit_en[0]), 32'd1);
        chk("e3_hit_dy16",  32'(bus.enemy_hit_en[3]), 32'd0);
        set_pos(1, 116, 100);
        frame(20, 1'b0);
        chk("e1_hit_dx16",  32'(bus.enemy_hit_en[1]), 32'd0);

        // Full shield cycle on enemy 0; threats inside cooldown are ignored.
        do_reset();
        clear_inputs();
        bus.attack_x = 10'd200; bus.attack_y = 10'd200;
        set_pos(0, 230, 200);
        up_cnt = 0;
        rise   = -1;
        for (int k = 0; k <= 185; k++) begin
            bus.attack_active = (k == 0) || (k >= 100 && k <= 110) || (k == 166);
            frame((k == 5) ? 25 : 1, 1'b0);
            if (k < 166 && bus.is_enemy_shield[0]) begin
                up_cnt++;
                if (rise < 0) rise = k;
            end
        end
        chk("shield_rise_edge", 32'(rise),   SH_ON ? 32'd15 : 32'hFFFF_FFFF);
        chk("shield_up_len",    32'(up_cnt), SH_ON ? 32'd60 : 32'd0);
        chk("shield_rearm",     32'(bus.is_enemy_shield[0]), 32'(SH_ON));

        // Death while shield is up.
        do_reset();
        clear_inputs();
        bus.attack_x = 10'd500; bus.attack_y = 10'd500;
        set_pos(2, 510, 510);
        for (int k = 0; k <= 40; k++) begin
            bus.attack_active = (k == 0) || (k == 20) || (k == 22);
            bus.dead[2]       = (k == 20);
            frame(1, 1'b0);
            if (k == 20) begin
                chk("dead_hit",    32'(bus.enemy_hit_en[2]),    32'd0);
                chk("dead_shield", 32'(bus.is_enemy_shield[2]), 32'd0);
            end
        end
        chk("dead_rearm", 32'(bus.is_enemy_shield[2]), 32'(SH_ON));

        // Reset landing on the frame-edge cycle while enemy 0 is raising.
        do_reset();
        clear_inputs();
        bus.attack_active = 1'b1;
        bus.attack_x = 10'd300; bus.attack_y = 10'd300;
        set_pos(0, 305, 300);
        frame(1, 1'b0);
        for (int k = 0; k < 5; k++) frame(1, 1'b0);
        frame_clk = 1'b1;
        @(posedge Clk); #1;
        Reset     = 1'b1;
        frame_clk = 1'b0;
        @(posedge Clk); #1;
        chk("rst_mid_hit",    32'(bus.enemy_hit_en),    32'd0);
        chk("rst_mid_shield", 32'(bus.is_enemy_shield), 32'd0);
        Reset = 1'b0;
        model_reset();
        bus.attack_active = 1'b0;
        for (int k = 0; k < 20; k++) frame(1, 1'b0);

        // Randomized frames, inputs scrambled mid-frame.
        do_reset();
        randomize_inputs();
        for (int k = 0; k < 500; k++) begin
            frame(int'($urandom_range(0, 4)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/enemy_hit_gen4.md
# enemy_hit_gen4

Producer side of the enemy damage interface. Each frame it generates the per-enemy `enemy_hit_en[0:3]` and `is_enemy_shield[0:3]` levels consumed by the enemy health tracker, and takes back that tracker's `dead[0:3]`. Hits come from overlap between the player attack box and each enemy's hit box. Shields come from a per-enemy frame-counted shield state machine triggered by nearby attacks.

## Interface
Parameters:
- `HIT_HALF_W`, 16: hit-box half width, pixels
- `HIT_HALF_H`, 16: hit-box half height, pixels
- `THREAT_HALF`, 48: square threat-zone half size, pixels, for shield trigger
- `RAISE_FRAMES`, 15: frames spent raising the shield, range 1..127
- `UP_FRAMES`, 60: frames the shield stays up, range 1..127
- `COOL_FRAMES`, 90: frames of cooldown before re-trigger, range 1..127

Ports:
- `Clk` in 1: system clock
- `Reset` in 1: synchronous, active-high
- `frame_clk` in 1: frame strobe, ~60 Hz, asynchronous level
- `attack_active` in 1: player attack box valid this frame
- `attack_x`, `attack_y` in 10 each: attack box centre, unsigned pixels
- `enemy_x[0:3]`, `enemy_y[0:3]` in 10 each: enemy centres, unsigned pixels
- `dead[0:3]` in 1 each: from health tracker; 1 means the enemy is removed
- `enemy_hit_en[0:3]` out 1 each: attack overlaps enemy this frame
- `is_enemy_shield[0:3]` out 1 each: enemy shield fully up

## Operation
- Frame-edge detect:
  - `fc_d <= frame_clk`
  - `fe <= frame_clk & ~fc_d`
  - `fe` is a one-Clk pulse. All state below updates only on cycles where `fe` = 1; otherwise it holds.
- Distance math:
  - `dx = attack_x - enemy_x[i]` as 11-bit signed. Take `|dx|` in 10 bits. Same for `dy`.
  - No wrap: 11 bits covers ±1023.
- Hit, for each i at `fe`:
  - `enemy_hit_en[i] <= attack_active & ~dead[i] & (|dx| < HIT_HALF_W) & (|dy| < HIT_HALF_H)`
  - The compares are strict.
  - Hit is independent of shield state; damage masking by the shield belongs to the health tracker.
- Threat, for each i: `attack_active & (|dx| < THREAT_HALF) & (|dy| < THREAT_HALF)`.
- Shield FSM per enemy, with a 7-bit frame counter `cnt`. On entering a state with N frames, `cnt` loads N-1. At each `fe` in that state, `cnt` = 0 means transition; otherwise decrement. Each timed state therefore lasts exactly N frame edges.
  - `SH_DOWN`: if threat & ~dead go to `SH_RAISE`, load `RAISE_FRAMES-1`.
  - `SH_RAISE`: at count expiry go to `SH_UP`, load `UP_FRAMES-1`.
  - `SH_UP`: at count expiry go to `SH_COOL`, load `COOL_FRAMES-1`. Threat does not extend `SH_UP`.
  - `SH_COOL`: at count expiry go to `SH_DOWN`. Threat is ignored in this state.
  - `dead[i]` = 1 at any `fe`: force `SH_DOWN`, `cnt` = 0. This has priority over all other transitions.
- `is_enemy_shield[i]` is registered: 1 only in `SH_UP` and not dead.
- The four enemies are fully independent.

## Timing
- Reset values:
  - `enemy_hit_en` = 0, `is_enemy_shield` = 0 for all four enemies
  - all FSMs in `SH_DOWN`, `cnt` = 0, `fc_d` = 0, `fe` = 0
- `Reset` overrides everything, including a frame edge in the same cycle. Reset mid-shield returns the enemy to `SH_DOWN` immediately.
- Latency:
  - `frame_clk` sampled high at cycle t → `fe` high at t+1 → outputs change at t+2.
  - Outputs are then held level for the whole frame, so the health tracker samples a stable value on its own edge.
- Input sampling: inputs other than `frame_clk` are sampled only in the `fe` cycle.
- `dead` and threat asserted in the same `fe`: dead wins, FSM stays `SH_DOWN`, hit = 0.
- `frame_clk` held high for many cycles produces a single `fe`.

## Configuration
- `ENEMY_SHIELD_EN` defined: shield FSMs built as described.
- `ENEMY_SHIELD_EN` undefined:
  - FSMs and counters are not instantiated.
  - `is_enemy_shield[i]` is tied to 0.
  - Hit generation is unchanged.

## Structure
- Package `enemy_pkg` holds:
  - `shield_state_t` enum: `SH_DOWN`, `SH_RAISE`, `SH_UP`, `SH_COOL`
  - `COORD_W` = 10
  - `FCNT_W` = 7
  - default frame-count constants
- Sub-module `enemy_shield_fsm`:
  - one instance per enemy, generated
  - inputs: `Clk`, `Reset`, `fe`, `threat`, `dead`
  - output: `shield`
- The top level holds the edge detector, distance math and hit registers.

## Test plan
- **Reset, then idle:** reset, then 10 frames with `attack_active` = 0 → all outputs 0, FSMs in `SH_DOWN`.
- **Hit box boundary:** `attack_x` = 100, `enemy_x[1]` = 115, equal y, `attack_active` = 1 → `enemy_hit_en[1]` = 1 from t+2, held the whole frame. `enemy_x[1]` = 116 → 0.
- **Shield cycle:** enemy 0 at a distance of 30, one threat frame, defaults → `is_enemy_shield[0]` rises after 15 frame edges, stays 1 for exactly 60 edges, then 90 cooldown edges during which threat is ignored, then re-arms.
- **Death during shield:** `dead[2]` = 1 while enemy 2 is in `SH_UP` → `is_enemy_shield[2]` and `enemy_hit_en[2]` = 0 at the next `fe`. Clearing `dead` restarts from `SH_DOWN`.
- **Reset mid-raise:** reset asserted in the same cycle as `fe` → all outputs 0 next cycle, counters cleared.
- **`ENEMY_SHIELD_EN` undefined:** any threat pattern → `is_enemy_shield` stays 0, hits unchanged.
